// File: rtl/parity_accumulator.sv
// parity_accumulator
//   Accumulates a frame of WIDTH-bit words by bitwise XOR and presents the
//   reduced word, its parity and the frame length once the frame closes.
//   A frame closes on a word flagged in_last, or on the MAX_LEN-th word,
//   whichever comes first. The result is held until the consumer takes it.
//   While the result is held, no input is accepted.
//
// Ports
//   clk        : clock; all state changes on its rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : in_data / in_last / mode are valid this cycle
//   in_ready   : block accepts a word this cycle (high in ACC)
//   in_data    : word to accumulate
//   in_last    : this word closes the frame
//   mode       : 0 = XOR result, 1 = XNOR (inverted) result
//   out_valid  : result fields hold a completed frame (high in HOLD)
//   out_ready  : consumer takes the result this cycle
//   out_data   : bitwise XOR reduction of the frame (inverted if mode was 1)
//   out_parity : XOR of all out_data bits
//   out_count  : number of words in the frame (1..MAX_LEN)
module parity_accumulator #(
  parameter  int WIDTH   = 4,
  parameter  int MAX_LEN = 8,
  localparam int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity,
  output logic [CW-1:0]    out_count
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [CW-1:0]    cnt, cnt_nxt, cnt_inc;
  logic             mode_q, mode_nxt, eff_mode;
  logic [WIDTH-1:0] word_res;
  logic             close;
  logic [WIDTH-1:0] out_data_nxt;
  logic             out_parity_nxt;
  logic [CW-1:0]    out_count_nxt;

  // Both handshake flags are pure decodes of the state register.
  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);

  always_comb begin
    state_nxt      = state;
    acc_nxt        = acc;
    cnt_nxt        = cnt;
    mode_nxt       = mode_q;
    out_data_nxt   = out_data;
    out_parity_nxt = out_parity;
    out_count_nxt  = out_count;

    cnt_inc  = cnt + 1'b1;
    // The first word of a frame (cnt == 0) supplies the mode directly, so a
    // single-word frame uses the mode sampled on that same word.
    eff_mode = (cnt == '0) ? mode : mode_q;
    word_res = (acc ^ in_data) ^ {WIDTH{eff_mode}};
    close    = in_last || (cnt_inc == CW'(MAX_LEN));

    case (state)
      ACC: begin
        if (in_valid) begin
          acc_nxt  = acc ^ in_data;
          cnt_nxt  = cnt_inc;
          mode_nxt = eff_mode;
          if (close) begin
            state_nxt      = HOLD;
            out_data_nxt   = word_res;
            out_parity_nxt = ^word_res;
            out_count_nxt  = cnt_inc;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = ACC;
          acc_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACC;
      acc        <= '0;
      cnt        <= '0;
      mode_q     <= 1'b0;
      out_data   <= '0;
      out_parity <= 1'b0;
      out_count  <= '0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      cnt        <= cnt_nxt;
      mode_q     <= mode_nxt;
      out_data   <= out_data_nxt;
      out_parity <= out_parity_nxt;
      out_count  <= out_count_nxt;
    end
  end

endmodule

// File: tb/tb_parity_accumulator.sv
module tb_parity_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       mode;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_parity;
  logic [3:0] out_count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  parity_accumulator #(.WIDTH(4), .MAX_LEN(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_parity (out_parity),
    .out_count  (out_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word for exactly one edge (block must be in ACC).
  task automatic send(input logic [3:0] d, input logic last, input logic m);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    mode     = m;
    step();
    in_valid = 1'b0;
    in_data  = 4'hx;
    in_last  = 1'bx;
    mode     = 1'bx;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [3:0] d,
                           input logic p, input logic [3:0] c);
    chk({tag, ".out_valid"},  32'(out_valid),  32'(v));
    chk({tag, ".in_ready"},   32'(in_ready),   32'(!v));
    chk({tag, ".out_data"},   32'(out_data),   32'(d));
    chk({tag, ".out_parity"}, 32'(out_parity), 32'(p));
    chk({tag, ".out_count"},  32'(out_count),  32'(c));
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    in_last   = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #2;
    check_out("reset0", 1'b0, 4'b0000, 1'b0, 4'd0);
    #5 rst_n = 1'b1;
    step();

    // Basic XOR frame: 0011 ^ 0101 ^ 1111 = 1001
    send(4'b0011, 1'b0, 1'b0);
    send(4'b0101, 1'b0, 1'b0);
    chk("xor.mid.out_valid", 32'(out_valid), 32'(0));
    send(4'b1111, 1'b1, 1'b0);
    check_out("xor", 1'b1, 4'b1001, 1'b0, 4'd3);
    take_result();
    chk("xor.taken.out_valid", 32'(out_valid), 32'(0));
    chk("xor.taken.in_ready",  32'(in_ready),  32'(1));

    // XNOR with mode dropping mid-frame; then backpressure for 5 cycles
    send(4'b0011, 1'b0, 1'b1);
    send(4'b0101, 1'b0, 1'b0);
    send(4'b1111, 1'b1, 1'b0);
    check_out("xnor", 1'b1, 4'b0110, 1'b0, 4'd3);
    for (int i = 0; i < 5; i++) begin
      step();
      check_out($sformatf("bp%0d", i), 1'b1, 4'b0110, 1'b0, 4'd3);
    end
    take_result();
    chk("bp.release.out_valid", 32'(out_valid), 32'(0));
    chk("bp.release.in_ready",  32'(in_ready),  32'(1));

    // Forced close after MAX_LEN words of 0001
    for (int i = 0; i < 7; i++) send(4'b0001, 1'b0, 1'b0);
    chk("force.7.out_valid", 32'(out_valid), 32'(0));
    chk("force.7.in_ready",  32'(in_ready),  32'(1));
    send(4'b0001, 1'b0, 1'b0);
    check_out("force", 1'b1, 4'b0000, 1'b0, 4'd8);
    // 9th word held valid while the result is pending: must be refused
    in_valid = 1'b1;
    in_data  = 4'b0100;
    in_last  = 1'b1;
    mode     = 1'b0;
    step();
    step();
    check_out("force.hold", 1'b1, 4'b0000, 1'b0, 4'd8);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("force.taken.out_valid", 32'(out_valid), 32'(0));
    chk("force.taken.in_ready",  32'(in_ready),  32'(1));
    step();
    in_valid = 1'b0;
    check_out("ninth", 1'b1, 4'b0100, 1'b1, 4'd1);
    take_result();

    // Reset mid-frame after two accepted words
    send(4'b1111, 1'b0, 1'b1);
    send(4'b0001, 1'b0, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check_out("rst.mid", 1'b0, 4'b0000, 1'b0, 4'd0);
    #2 rst_n = 1'b1;
    send(4'b1010, 1'b1, 1'b0);
    check_out("single", 1'b1, 4'b1010, 1'b0, 4'd1);

    // Reset while a result is held
    #3 rst_n = 1'b0;
    #1;
    check_out("rst.hold", 1'b0, 4'b0000, 1'b0, 4'd0);
    #2 rst_n = 1'b1;
    step();
    check_out("rst.after", 1'b0, 4'b0000, 1'b0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
